// File: rtl/parity_sched_pkg.sv
// Shared types and helpers for the parity_sched block: FSM state encoding,
// id-width sizing and round-robin index stepping.
package parity_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_APPEND = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // A single requester would give $clog2 == 0, so clamp to one bit.
  function automatic int id_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// One-bit serial parity accumulator: p is the running XOR of x over enabled
// cycles since the last clr; clr wins over en.
module parity_acc (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic p
);

  logic r_p;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_p <= 1'b0;
    else if (clr)   r_p <= 1'b0;
    else if (en)    r_p <= r_p ^ x;
  end

  assign p = r_p;

endmodule

// File: rtl/parity_sched.sv
// Round-robin scheduler feeding one shared serial parity accumulator.
// Optional macro PARITY_SCHED_APPEND_EN appends the parity bit to the serial stream.
module parity_sched
  import parity_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   par_out,
  output logic                   par_valid,
  output logic [ID_W-1:0]        par_id
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_par_id;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_par_hold;

  logic             w_any;
  logic [ID_W-1:0]  w_win;
  logic [N_REQ-1:0] w_gnt;
  logic             w_start;
  logic             w_acc;
  logic             w_bit;
  logic             w_bit_vld;
  logic             w_done;

  // Arbiter: first set request at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    w_gnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_any && req[idx]) begin
        w_any = 1'b1;
        w_win = ID_W'(idx);
      end
    end
    if (w_any) w_gnt[w_win] = 1'b1;
  end

  assign w_start = (r_state == ST_IDLE) && w_any;
  assign w_done  = (r_state == ST_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_par_hold <= 1'b0;
      r_par_id   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_cnt <= '0;
`ifdef PARITY_SCHED_APPEND_EN
            r_state <= ST_APPEND;
`else
            r_state <= ST_DONE;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef PARITY_SCHED_APPEND_EN
        ST_APPEND: r_state <= ST_DONE;
`endif
        ST_DONE: begin
          r_ptr      <= ID_W'(rr_next(int'(r_id), N_REQ));
          r_par_hold <= w_acc;
          r_par_id   <= r_id;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Word and id are pure data; bit_out/par_id are gated by state, so no reset.
  always_ff @(posedge clock) begin
    if (w_start) begin
      r_word <= data[int'(w_win)*WIDTH +: WIDTH];
      r_id   <= w_win;
    end
  end

  always_comb begin
    w_bit     = 1'b0;
    w_bit_vld = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        w_bit     = r_word[r_cnt];
        w_bit_vld = 1'b1;
      end
`ifdef PARITY_SCHED_APPEND_EN
      ST_APPEND: begin
        w_bit     = w_acc;
        w_bit_vld = 1'b1;
      end
`endif
      default: begin
        w_bit     = 1'b0;
        w_bit_vld = 1'b0;
      end
    endcase
  end

  parity_acc u_acc (
    .clock (clock),
    .reset (reset),
    .clr   (w_start),
    .en    (r_state == ST_SHIFT),
    .x     (w_bit),
    .p     (w_acc)
  );

  assign gnt       = (r_state == ST_IDLE) ? w_gnt : '0;
  assign busy      = (r_state != ST_IDLE);
  assign bit_out   = w_bit;
  assign bit_valid = w_bit_vld;
  assign par_valid = w_done;
  assign par_out   = w_done ? w_acc : r_par_hold;
  assign par_id    = w_done ? r_id  : r_par_id;

endmodule
